// File: rtl/mul_pipe_n_pkg.sv
// Shared types and helpers for the parametrised RV32M/RV64M multiply pipeline.
// Operation encoding and the default configuration used by decode.
package mul_pipe_n_pkg;

   localparam int DEF_XLEN   = 32;
   localparam int DEF_STAGES = 4;
   localparam int DEF_TAG_W  = 5;
   localparam int DEF_ID_W   = 8;

   typedef enum logic [1:0] {
      MUL_OP_MUL    = 2'd0,
      MUL_OP_MULH   = 2'd1,
      MUL_OP_MULHSU = 2'd2,
      MUL_OP_MULHU  = 2'd3
   } mul_op_t;

   // Request record as issued by decode in the default configuration.
   typedef struct packed {
      mul_op_t               op;
      logic [DEF_XLEN-1:0]   a;
      logic [DEF_XLEN-1:0]   b;
      logic [DEF_TAG_W-1:0]  rd;
      logic                  wen;
      logic [DEF_ID_W-1:0]   id;
   } mul_req_t;

   function automatic logic op_a_signed(input mul_op_t op);
      logic r_sgn;
      case (op)
         MUL_OP_MULH, MUL_OP_MULHSU: r_sgn = 1'b1;
         default:                    r_sgn = 1'b0;
      endcase
      return r_sgn;
   endfunction

   function automatic logic op_b_signed(input mul_op_t op);
      logic r_sgn;
      case (op)
         MUL_OP_MULH: r_sgn = 1'b1;
         default:     r_sgn = 1'b0;
      endcase
      return r_sgn;
   endfunction

   function automatic logic op_high_half(input mul_op_t op);
      logic r_hi;
      case (op)
         MUL_OP_MUL: r_hi = 1'b0;
         default:    r_hi = 1'b1;
      endcase
      return r_hi;
   endfunction

endpackage

// File: rtl/mul_pipe_n_if.sv
// Issue/retire handshake bundle of the multiply pipeline, plus the busy-register vector.
// master = decode/consumer side, slave = the pipeline itself.
interface mul_pipe_n_if
   import mul_pipe_n_pkg::*;
#(
   parameter int XLEN  = DEF_XLEN,
   parameter int TAG_W = DEF_TAG_W,
   parameter int ID_W  = DEF_ID_W
);
   logic                    in_valid;
   logic                    in_ready;
   mul_op_t                 in_op;
   logic [XLEN-1:0]         in_a;
   logic [XLEN-1:0]         in_b;
   logic [TAG_W-1:0]        in_rd;
   logic                    in_wen;
   logic [ID_W-1:0]         in_id;
   logic                    flush;
   logic                    out_valid;
   logic                    out_ready;
   logic [XLEN-1:0]         out_result;
   logic [TAG_W-1:0]        out_rd;
   logic                    out_wen;
   logic [ID_W-1:0]         out_id;
   logic [(2**TAG_W)-1:0]   rd_busy;

   modport master (
      output in_valid, in_op, in_a, in_b, in_rd, in_wen, in_id, flush, out_ready,
      input  in_ready, out_valid, out_result, out_rd, out_wen, out_id, rd_busy
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, in_rd, in_wen, in_id, flush, out_ready,
      output in_ready, out_valid, out_result, out_rd, out_wen, out_id, rd_busy
   );
endinterface

// File: rtl/mul_pipe_n_chk.sv
// Handshake invariants of the multiply pipeline: held output payload stays stable,
// and a completely full, stalled pipe never advertises ready.
module mul_pipe_n_chk #(
   parameter int XLEN   = 32,
   parameter int STAGES = 4,
   parameter int TAG_W  = 5,
   parameter int ID_W   = 8
) (
   input logic               clk,
   input logic               rst,
   input logic [STAGES-1:0]  valid,
   input logic               in_ready,
   input logic               flush,
   input logic               out_valid,
   input logic               out_ready,
   input logic [XLEN-1:0]    out_result,
   input logic [TAG_W-1:0]   out_rd,
   input logic               out_wen,
   input logic [ID_W-1:0]    out_id
);
   a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
      (out_valid && !out_ready && !flush) |=>
         ($stable(out_result) && $stable(out_rd) && $stable(out_wen) && $stable(out_id)));

   a_full_not_ready: assert property (@(posedge clk) disable iff (!rst)
      !((&valid) && !out_ready && in_ready));
endmodule

// File: rtl/mul_pipe_n_core.sv
// Combinational signed/unsigned multiplier with product-half select.
// Operands are sign- or zero-extended to the full product width so one unsigned multiply covers all four ops.
module mul_pipe_n_core
   import mul_pipe_n_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
) (
   input  mul_op_t          i_op,
   input  logic [XLEN-1:0]  i_a,
   input  logic [XLEN-1:0]  i_b,
   output logic [XLEN-1:0]  o_result
);
   logic                   w_a_sx;
   logic                   w_b_sx;
   logic [2*XLEN-1:0]      w_a_wide;
   logic [2*XLEN-1:0]      w_b_wide;
   logic [2*XLEN-1:0]      w_prod;

   assign w_a_sx   = op_a_signed(i_op) & i_a[XLEN-1];
   assign w_b_sx   = op_b_signed(i_op) & i_b[XLEN-1];
   assign w_a_wide = {{XLEN{w_a_sx}}, i_a};
   assign w_b_wide = {{XLEN{w_b_sx}}, i_b};
   assign w_prod   = w_a_wide * w_b_wide;

   // product half selection
   always_comb begin
      o_result = w_prod[XLEN-1:0];
      if (op_high_half(i_op)) begin
         o_result = w_prod[2*XLEN-1:XLEN];
      end else begin
         o_result = w_prod[XLEN-1:0];
      end
   end
endmodule

// File: rtl/mul_pipe_n.sv
// Parametrised multiply pipeline: product formed at stage 0, carried through STAGES
// registers with per-stage back-pressure, bubble collapse, flush and a busy-register scoreboard.
module mul_pipe_n
   import mul_pipe_n_pkg::*;
#(
   parameter int XLEN   = DEF_XLEN,
   parameter int STAGES = DEF_STAGES,
   parameter int TAG_W  = DEF_TAG_W,
   parameter int ID_W   = DEF_ID_W
) (
   input logic            clk,
   input logic            rst,
   mul_pipe_n_if.slave    bus
);
   localparam int NREG = 2**TAG_W;

   typedef struct packed {
      logic [XLEN-1:0]   res;
      logic [TAG_W-1:0]  rd;
      logic              wen;
      logic [ID_W-1:0]   id;
   } stage_t;

   logic [STAGES-1:0]  r_valid;
   stage_t             r_pay [STAGES];
   logic [STAGES-1:0]  w_adv;
   logic [STAGES-1:0]  w_src_valid;
   stage_t             w_src_pay [STAGES];
   logic [XLEN-1:0]    w_product;
   logic               w_accept;
   logic [NREG-1:0]    w_busy;

   mul_pipe_n_core #(.XLEN(XLEN)) u_core (
      .i_op     (bus.in_op),
      .i_a      (bus.in_a),
      .i_b      (bus.in_b),
      .o_result (w_product)
   );

   // A slot may load when it is empty or its occupant moves on; this chain is combinational end to end.
   always_comb begin
      w_adv = '0;
      w_adv[STAGES-1] = ~r_valid[STAGES-1] | bus.out_ready;
      for (int i = STAGES - 2; i >= 0; i--) begin
         w_adv[i] = ~r_valid[i] | w_adv[i+1];
      end
   end

   assign w_accept = bus.in_valid & w_adv[0] & ~bus.flush;

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      if (g == 0) begin : g_head
         assign w_src_valid[g] = w_accept;
         assign w_src_pay[g]   = '{res: w_product, rd: bus.in_rd, wen: bus.in_wen, id: bus.in_id};
      end else begin : g_body
         assign w_src_valid[g] = r_valid[g-1];
         assign w_src_pay[g]   = r_pay[g-1];
      end
   end

   // stage occupancy; flush empties every slot at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= '0;
      end else if (bus.flush) begin
         r_valid <= '0;
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            if (w_adv[i]) begin
               r_valid[i] <= w_src_valid[i];
            end
         end
      end
   end

   // stage payload, loaded only with real ops and deliberately left unreset
   always_ff @(posedge clk) begin
      for (int i = 0; i < STAGES; i++) begin
         if (w_adv[i] && w_src_valid[i]) begin
            r_pay[i] <= w_src_pay[i];
         end
      end
   end

   // one-hot OR of every pending destination; x0 is reported and masked by decode
   always_comb begin
      w_busy = '0;
      for (int i = 0; i < STAGES; i++) begin
         w_busy = w_busy | (NREG'(r_valid[i] & r_pay[i].wen) << r_pay[i].rd);
      end
   end

   assign bus.in_ready   = w_adv[0];
   assign bus.out_valid  = r_valid[STAGES-1] & ~bus.flush;
   assign bus.out_result = r_pay[STAGES-1].res;
   assign bus.out_rd     = r_pay[STAGES-1].rd;
   assign bus.out_wen    = r_pay[STAGES-1].wen;
   assign bus.out_id     = r_pay[STAGES-1].id;
   assign bus.rd_busy    = w_busy;

   mul_pipe_n_chk #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W), .ID_W(ID_W)) u_chk (
      .clk        (clk),
      .rst        (rst),
      .valid      (r_valid),
      .in_ready   (bus.in_ready),
      .flush      (bus.flush),
      .out_valid  (bus.out_valid),
      .out_ready  (bus.out_ready),
      .out_result (bus.out_result),
      .out_rd     (bus.out_rd),
      .out_wen    (bus.out_wen),
      .out_id     (bus.out_id)
   );
endmodule

// File: tb/tb_mul_pipe_n.sv
// Scoreboard bench for mul_pipe_n (XLEN=32, STAGES=4): expected results queued at acceptance,
// completed handshakes collected by a monitor, and each scenario task compares the two.
module tb_mul_pipe_n;
   import mul_pipe_n_pkg::*;

   localparam int XLEN   = 32;
   localparam int STAGES = 4;
   localparam int TAG_W  = 5;
   localparam int ID_W   = 8;

   typedef struct {
      logic [XLEN-1:0]  res;
      logic [TAG_W-1:0] rd;
      logic             wen;
      logic [ID_W-1:0]  id;
      int               cyc;
   } txn_t;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   txn_t exp_q[$];
   txn_t obs_q[$];
   txn_t mon_t;

   mul_pipe_n_if #(.XLEN(XLEN), .TAG_W(TAG_W), .ID_W(ID_W)) bus ();

   mul_pipe_n #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W), .ID_W(ID_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // completed handshakes, stamped with the edge on which they retire
   always @(negedge clk) begin
      if (rst && bus.out_valid && bus.out_ready) begin
         mon_t.res = bus.out_result;
         mon_t.rd  = bus.out_rd;
         mon_t.wen = bus.out_wen;
         mon_t.id  = bus.out_id;
         mon_t.cyc = cyc + 1;
         obs_q.push_back(mon_t);
      end
   end

   function automatic logic [31:0] ref_mul(input mul_op_t op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         MUL_OP_MULH:   p = sa * sb;
         MUL_OP_MULHSU: p = sa * ub;
         default:       p = ua * ub;
      endcase
      return (op == MUL_OP_MUL) ? p[31:0] : p[63:32];
   endfunction

   task automatic offer(input mul_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic wen, input logic [7:0] id,
                        input bit keep, input bit rand_rdy, input logic [31:0] exp_res,
                        output bit ok);
      txn_t t;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_op = op;
      bus.in_a = a;
      bus.in_b = b;
      bus.in_rd = rd;
      bus.in_wen = wen;
      bus.in_id = id;
      for (int k = 0; k < 40 && !ok; k++) begin
         if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (bus.in_ready && !bus.flush) begin
            ok = 1'b1;
            if (keep) begin
               t.res = exp_res; t.rd = rd; t.wen = wen; t.id = id; t.cyc = cyc + 1;
               exp_q.push_back(t);
            end
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_obs(input int n, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         if (obs_q.size() >= n) ok = 1'b1;
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
      n_checks++; if (bus.rd_busy !== 32'h0) begin n_fail++; $display("FAIL reset_rd_busy got %h want 0", bus.rd_busy); end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_latency();
      bit ok, ok2;
      txn_t o, e;
      exp_q.delete(); obs_q.delete();
      bus.out_ready = 1'b1;
      offer(MUL_OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1, 8'h11, 1'b1, 1'b0, 32'hFFFF_FFEB, ok);
      @(negedge clk);
      n_checks++; if (bus.rd_busy !== 32'h0000_0020) begin n_fail++; $display("FAIL lat_rd_busy got %h want 00000020", bus.rd_busy); end
      wait_obs(1, ok2);
      n_checks++; if (!(ok && ok2)) begin n_fail++; $display("FAIL lat_timeout got %b%b want 11", ok, ok2); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (o.res !== e.res || o.rd !== e.rd || o.id !== e.id || o.wen !== e.wen) begin
            n_fail++; $display("FAIL lat_data got %h/%0d/%h want %h/%0d/%h", o.res, o.rd, o.id, e.res, e.rd, e.id);
         end
         n_checks++; if (o.cyc - e.cyc != STAGES) begin n_fail++; $display("FAIL lat_cycles got %0d want %0d", o.cyc - e.cyc, STAGES); end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int acc = 0;
      int first;
      txn_t o, e;
      exp_q.delete(); obs_q.delete();
      bus.out_ready = 1'b1;
      offer(MUL_OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd1, 1'b1, 8'h21, 1'b1, 1'b0, 32'h4000_0000, ok); acc += int'(ok);
      offer(MUL_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1, 8'h22, 1'b1, 1'b0, 32'hFFFF_FFFE, ok); acc += int'(ok);
      offer(MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1, 8'h23, 1'b1, 1'b0, 32'hFFFF_FFFF, ok); acc += int'(ok);
      wait_obs(3, ok);
      n_checks++; if (!ok || acc != 3) begin n_fail++; $display("FAIL b2b_count got acc=%0d obs=%0d want 3", acc, obs_q.size()); end
      first = (obs_q.size() > 0) ? obs_q[0].cyc : 0;
      for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (o.res !== e.res || o.rd !== e.rd || o.id !== e.id) begin
            n_fail++; $display("FAIL b2b_data%0d got %h/%0d/%h want %h/%0d/%h", i, o.res, o.rd, o.id, e.res, e.rd, e.id);
         end
         n_checks++;
         if (o.cyc != first + i || o.cyc - e.cyc != STAGES) begin
            n_fail++; $display("FAIL b2b_timing%0d got cyc %0d lat %0d want cyc %0d lat %0d", i, o.cyc, o.cyc - e.cyc, first + i, STAGES);
         end
      end
   endtask

   task automatic test_capacity();
      bit ok, ok2;
      int acc = 0;
      int hi = 0;
      int span;
      txn_t o, e;
      exp_q.delete(); obs_q.delete();
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         offer(MUL_OP_MUL, 32'(i), 32'd3, 5'(i), 1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 32'(i * 3), ok);
         acc += int'(ok);
      end
      bus.in_valid = 1'b1; bus.in_op = MUL_OP_MUL; bus.in_a = 32'd5; bus.in_b = 32'd3;
      bus.in_rd = 5'd5; bus.in_wen = 1'b1; bus.in_id = 8'h45;
      repeat (4) begin
         @(negedge clk);
         if (bus.in_ready) hi++;
         @(posedge clk); #1;
      end
      @(negedge clk);
      n_checks++; if (acc != 4 || exp_q.size() != 4) begin n_fail++; $display("FAIL cap_accepted got %0d want 4", exp_q.size()); end
      n_checks++; if (hi != 0) begin n_fail++; $display("FAIL cap_in_ready got %0d ready cycles want 0", hi); end
      n_checks++; if (bus.rd_busy !== 32'h0000_001E) begin n_fail++; $display("FAIL cap_rd_busy got %h want 0000001e", bus.rd_busy); end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      offer(MUL_OP_MUL, 32'd5, 32'd3, 5'd5, 1'b1, 8'h45, 1'b1, 1'b0, 32'd15, ok);
      offer(MUL_OP_MUL, 32'd6, 32'd3, 5'd6, 1'b1, 8'h46, 1'b1, 1'b0, 32'd18, ok2);
      n_checks++; if (!(ok && ok2)) begin n_fail++; $display("FAIL cap_late_accept got %b%b want 11", ok, ok2); end
      wait_obs(6, ok);
      span = (obs_q.size() >= 4) ? obs_q[3].cyc - obs_q[0].cyc : -1;
      n_checks++; if (!ok || span != 3) begin n_fail++; $display("FAIL cap_drain got span %0d obs %0d want span 3 obs 6", span, obs_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (o.res !== e.res || o.rd !== e.rd || o.id !== e.id) begin
            n_fail++; $display("FAIL cap_order got %h/%0d want %h/%0d", o.res, o.rd, e.res, e.rd);
         end
      end
   endtask

   task automatic test_collapse();
      bit ok;
      txn_t o, e;
      exp_q.delete(); obs_q.delete();
      bus.out_ready = 1'b1;
      offer(MUL_OP_MUL, 32'h0000_1234, 32'h0000_0010, 5'd7, 1'b1, 8'h51, 1'b1, 1'b0, 32'h0001_2340, ok);
      idle(1);
      offer(MUL_OP_MULHU, 32'h8000_0000, 32'h0000_0004, 5'd8, 1'b1, 8'h52, 1'b1, 1'b0, 32'h0000_0002, ok);
      bus.out_ready = 1'b0;
      @(negedge clk);
      n_checks++; if (dut.r_valid !== 4'b0101) begin n_fail++; $display("FAIL col_setup got %b want 0101", dut.r_valid); end
      n_checks++; if (bus.rd_busy !== 32'h0000_0180) begin n_fail++; $display("FAIL col_rd_busy got %h want 00000180", bus.rd_busy); end
      @(posedge clk); #1; @(negedge clk);
      n_checks++; if (dut.r_valid !== 4'b1010) begin n_fail++; $display("FAIL col_fill got %b want 1010", dut.r_valid); end
      @(posedge clk); #1; @(negedge clk);
      n_checks++; if (dut.r_valid !== 4'b1100) begin n_fail++; $display("FAIL col_pack got %b want 1100", dut.r_valid); end
      @(posedge clk); #1; @(negedge clk);
      n_checks++; if (dut.r_valid !== 4'b1100 || bus.out_result !== 32'h0001_2340) begin
         n_fail++; $display("FAIL col_hold got %b/%h want 1100/00012340", dut.r_valid, bus.out_result);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      wait_obs(2, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL col_drain got %0d results want 2", obs_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (o.res !== e.res || o.rd !== e.rd || o.id !== e.id) begin
            n_fail++; $display("FAIL col_data got %h/%0d want %h/%0d", o.res, o.rd, e.res, e.rd);
         end
      end
   endtask

   task automatic test_flush();
      bit ok, ok2;
      txn_t o, e;
      exp_q.delete(); obs_q.delete();
      bus.out_ready = 1'b1;
      offer(MUL_OP_MUL, 32'd2, 32'd2, 5'd1, 1'b1, 8'h31, 1'b0, 1'b0, 32'd0, ok);
      offer(MUL_OP_MUL, 32'd3, 32'd3, 5'd2, 1'b1, 8'h32, 1'b0, 1'b0, 32'd0, ok);
      offer(MUL_OP_MUL, 32'd4, 32'd4, 5'd3, 1'b1, 8'h33, 1'b0, 1'b0, 32'd0, ok);
      idle(1);
      bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_rd = 5'd9; bus.in_id = 8'h39;
      @(negedge clk);
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %b want 0", bus.out_valid); end
      @(posedge clk); #1;
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.rd_busy !== 32'h0) begin n_fail++; $display("FAIL flush_rd_busy got %h want 0", bus.rd_busy); end
      idle(6);
      n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL flush_leak got %0d results want 0", obs_q.size()); end
      obs_q.delete();
      offer(MUL_OP_MULHU, 32'h0001_0000, 32'h0001_0000, 5'd4, 1'b1, 8'h3A, 1'b1, 1'b0, 32'h0000_0001, ok);
      wait_obs(1, ok2);
      n_checks++; if (!(ok && ok2) || obs_q.size() != 1) begin n_fail++; $display("FAIL flush_after got %0d results want 1", obs_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (o.res !== e.res || o.id !== e.id || o.cyc - e.cyc != STAGES) begin
            n_fail++; $display("FAIL flush_new got %h/%h lat %0d want %h/%h lat %0d", o.res, o.id, o.cyc - e.cyc, e.res, e.id, STAGES);
         end
      end
   endtask

   task automatic test_async_reset();
      bit ok, ok2;
      txn_t o, e;
      exp_q.delete(); obs_q.delete();
      bus.out_ready = 1'b1;
      offer(MUL_OP_MUL, 32'd5, 32'd5, 5'd10, 1'b1, 8'h61, 1'b0, 1'b0, 32'd0, ok);
      offer(MUL_OP_MUL, 32'd6, 32'd6, 5'd11, 1'b1, 8'h62, 1'b0, 1'b0, 32'd0, ok);
      offer(MUL_OP_MUL, 32'd7, 32'd7, 5'd12, 1'b1, 8'h63, 1'b0, 1'b0, 32'd0, ok);
      idle(1);
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre got %b want 1", bus.out_valid); end
      #2 rst = 1'b0;
      #1;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid got %b want 0", bus.out_valid); end
      n_checks++; if (bus.rd_busy !== 32'h0) begin n_fail++; $display("FAIL arst_rd_busy got %h want 0", bus.rd_busy); end
      @(posedge clk); #3 rst = 1'b1;
      idle(8);
      n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL arst_stale got %0d results want 0", obs_q.size()); end
      obs_q.delete();
      offer(MUL_OP_MULH, 32'hFFFF_FFFE, 32'h0000_0003, 5'd13, 1'b1, 8'h64, 1'b1, 1'b0, 32'hFFFF_FFFF, ok);
      wait_obs(1, ok2);
      n_checks++; if (!(ok && ok2)) begin n_fail++; $display("FAIL arst_after got %b%b want 11", ok, ok2); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (o.res !== e.res || o.rd !== e.rd || o.cyc - e.cyc != STAGES) begin
            n_fail++; $display("FAIL arst_new got %h/%0d lat %0d want %h/%0d lat %0d", o.res, o.rd, o.cyc - e.cyc, e.res, e.rd, STAGES);
         end
      end
   endtask

   task automatic test_random();
      bit ok;
      int acc = 0;
      mul_op_t op;
      logic [31:0] a, b;
      txn_t o, e;
      exp_q.delete(); obs_q.delete();
      for (int i = 0; i < 24; i++) begin
         op = mul_op_t'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0: a = 32'h8000_0000;
            1: a = 32'hFFFF_FFFF;
            default: a = $urandom;
         endcase
         b = ($urandom_range(0, 3) == 0) ? 32'h8000_0001 : $urandom;
         offer(op, a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 8'(i), 1'b1, 1'b1, ref_mul(op, a, b), ok);
         acc += int'(ok);
      end
      bus.out_ready = 1'b1;
      wait_obs(24, ok);
      n_checks++; if (!ok || acc != 24) begin n_fail++; $display("FAIL rnd_count got acc %0d obs %0d want 24", acc, obs_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (o.res !== e.res || o.rd !== e.rd || o.wen !== e.wen || o.id !== e.id) begin
            n_fail++; $display("FAIL rnd_data got %h/%0d/%b/%h want %h/%0d/%b/%h", o.res, o.rd, o.wen, o.id, e.res, e.rd, e.wen, e.id);
         end
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      bus.in_valid = 1'b0; bus.in_op = MUL_OP_MUL; bus.in_a = '0; bus.in_b = '0;
      bus.in_rd = '0; bus.in_wen = 1'b0; bus.in_id = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
      #23 rst = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_latency();
      test_back_to_back();
      test_capacity();
      test_collapse();
      test_flush();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
